// File: rtl/hdshk_pulse_tx.sv
// hdshk_pulse_tx: per-channel pulse-to-four-phase request transmitter.
// Each channel turns single-cycle events into full req/ack handshakes toward
// an asynchronous remote domain. Events that arrive while a handshake is in
// flight are counted in a saturating pending counter, with a sticky overflow flag.
module hdshk_pulse_tx #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       pulse_in,
  input  logic [NCH-1:0]       ack_async,
  output logic [NCH-1:0]       req_out,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done,
  output logic [NCH*CNT_W-1:0] pend_cnt,
  output logic [NCH-1:0]       ovf,
  input  logic [NCH-1:0]       ovf_clr
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PMAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] pend_inc_sat(input logic [CNT_W-1:0] v);
    return (v == PMAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] pend_dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   ev_hold;

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Synchronise the remote acknowledge; only the last stage feeds the FSM.
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async[g]};
    end

    // Channel state, pending count and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        pend_q  <= '0;
        req_q   <= 1'b0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        pend_q  <= pend_d;
        req_q   <= req_d;
        done_q  <= done_d;
        ovf_q   <= ovf_d;
      end
    end

    // Next state: handshake progress, event queuing and overflow (set beats clear).
    always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q & ~ovf_clr[g];
      ev_hold = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!ack_s && (pulse_in[g] || (pend_q != '0))) begin
            state_d = S_REQ;
            // A fresh event launches directly; otherwise a queued one is used.
            if (!pulse_in[g]) pend_d = pend_dec_sat(pend_q);
          end else begin
            ev_hold = pulse_in[g];
          end
        end
        S_REQ: begin
          ev_hold = pulse_in[g];
          if (ack_s) state_d = S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          ev_hold = pulse_in[g];
          if (!ack_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (ev_hold) begin
        if (pend_q == PMAX) ovf_d  = 1'b1;
        else                pend_d = pend_inc_sat(pend_q);
      end
      req_d = (state_d == S_REQ);
    end

    assign req_out[g]                  = req_q;
    assign done[g]                     = done_q;
    assign ovf[g]                      = ovf_q;
    assign busy[g]                     = (state_q != S_IDLE) || (pend_q != '0);
    assign pend_cnt[g*CNT_W +: CNT_W]  = pend_q;
  end

endmodule

// File: tb/tb_hdshk_pulse_tx.sv
// Testbench for hdshk_pulse_tx: directed scenarios plus randomized rounds,
// with a remote echo model and a done-pulse scoreboard.
module tb_hdshk_pulse_tx;
  localparam int NCH   = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 3;
  localparam int PMAX  = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       pulse_in;
  logic [NCH-1:0]       ack_async;
  logic [NCH-1:0]       req_out;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;
  logic [NCH*CNT_W-1:0] pend_cnt;
  logic [NCH-1:0]       ovf;
  logic [NCH-1:0]       ovf_clr;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int done_seen [NCH] = '{default: 0};

  logic [NCH-1:0] forced;
  logic [NCH-1:0] fval;
  int             dly [NCH];
  logic [NCH-1:0] ahist [0:7];

  hdshk_pulse_tx #(.NCH(NCH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .ack_async(ack_async),
    .req_out(req_out), .busy(busy), .done(done), .pend_cnt(pend_cnt),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int pend_of(input int ch);
    return int'(pend_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic drain(input int budget, input string nm);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (busy != '0)) && (n < budget)) begin
      step();
      n++;
    end
    chk({nm, "_outstanding"}, exp_q.size(), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  // Remote domain: echoes req_out as ack after dly cycles, or drives a forced level.
  initial begin
    logic [31:0] rhist [NCH];
    for (int i = 0; i < NCH; i++) rhist[i] = '0;
    ack_async = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        rhist[i]     = {rhist[i][30:0], req_out[i]};
        ack_async[i] = forced[i] ? fval[i] : rhist[i][dly[i]];
      end
    end
  end

  // History of ack_async as seen at each edge; reset empties the synchronizer.
  initial begin
    for (int k = 0; k < 8; k++) ahist[k] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < 8; k++) ahist[k] = '0;
      end else begin
        for (int k = 7; k > 0; k--) ahist[k] = ahist[k-1];
        ahist[0] = ack_async;
      end
    end
  end

  // Monitor: pop the scoreboard on each done pulse; check req only rises with ack_s low.
  initial begin
    logic [NCH-1:0] prev_req;
    int found;
    prev_req = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (done[i] === 1'b1) begin
          found = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k] == i) begin
              found = k;
              break;
            end
          end
          chk($sformatf("done_expected_ch%0d", i), int'(found >= 0), 1);
          if (found >= 0) begin
            exp_q.delete(found);
            done_seen[i]++;
          end
        end
        if ((req_out[i] === 1'b1) && (prev_req[i] == 1'b0))
          chk($sformatf("req_rise_ack_s_low_ch%0d", i), int'(ahist[SYNC][i]), 0);
      end
      prev_req = req_out;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "time limit reached");
  end

  initial begin
    int base;
    int bad;
    int cnt  [NCH];
    int left [NCH];
    int b6   [NCH];

    rst      = 1'b1;
    pulse_in = '0;
    ovf_clr  = '0;
    forced   = '1;
    fval     = '0;
    for (int i = 0; i < NCH; i++) dly[i] = 0;
    repeat (3) step();

    // Reset state
    chk("rst_req_out", int'(req_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pend_cnt), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    repeat (2) step();

    // Single event on channel 0, remote echoes after 3 cycles
    forced[0] = 1'b0;
    dly[0]    = 3;
    step();
    base = done_seen[0];
    pulse_in[0] = 1'b1;
    exp_q.push_back(0);
    step();
    pulse_in = '0;
    chk("s1_req_rise", int'(req_out[0]), 1);
    chk("s1_pend", pend_of(0), 0);
    bad = 0;
    for (int n = 0; (n < 60) && ((exp_q.size() != 0) || busy[0]); n++) begin
      step();
      if (pend_of(0) != 0) bad++;
    end
    chk("s1_pend_stays_zero", bad, 0);
    chk("s1_done_count", done_seen[0] - base, 1);
    chk("s1_busy_low", int'(busy[0]), 0);

    // Queuing on channel 1 with ack held low
    forced[1] = 1'b1;
    fval[1]   = 1'b0;
    base = done_seen[1];
    for (int n = 0; n < 5; n++) begin
      pulse_in[1] = 1'b1;
      exp_q.push_back(1);
      step();
    end
    pulse_in = '0;
    chk("s2_pend4", pend_of(1), 4);
    chk("s2_req_high", int'(req_out[1]), 1);
    forced[1] = 1'b0;
    dly[1]    = $urandom_range(0, 4);
    drain(400, "s2");
    chk("s2_done_count", done_seen[1] - base, 5);
    chk("s2_pend0", pend_of(1), 0);

    // Overflow on channel 2 with ack stuck low
    forced[2] = 1'b1;
    fval[2]   = 1'b0;
    base = done_seen[2];
    for (int n = 0; n < 8; n++) begin
      pulse_in[2] = 1'b1;
      exp_q.push_back(2);
      step();
    end
    chk("s3_pend_full", pend_of(2), PMAX);
    chk("s3_no_ovf_yet", int'(ovf[2]), 0);
    step();
    pulse_in = '0;
    chk("s3_ovf_set", int'(ovf[2]), 1);
    chk("s3_pend_held", pend_of(2), PMAX);
    ovf_clr[2] = 1'b1;
    step();
    ovf_clr = '0;
    chk("s3_ovf_cleared", int'(ovf[2]), 0);
    chk("s3_pend_after_clr", pend_of(2), PMAX);
    pulse_in[2] = 1'b1;
    ovf_clr[2]  = 1'b1;
    step();
    pulse_in = '0;
    ovf_clr  = '0;
    chk("s3_set_wins", int'(ovf[2]), 1);
    chk("s3_pend_sat", pend_of(2), PMAX);
    ovf_clr[2] = 1'b1;
    step();
    ovf_clr = '0;
    chk("s3_ovf_cleared2", int'(ovf[2]), 0);
    forced[2] = 1'b0;
    dly[2]    = $urandom_range(0, 6);
    drain(600, "s3");
    chk("s3_done_count", done_seen[2] - base, 8);
    chk("s3_ovf_final", int'(ovf[2]), 0);

    // Reset during REQ with pend=3 on channel 3; channel 2 ack raised beforehand
    forced[2] = 1'b1;
    fval[2]   = 1'b1;
    forced[3] = 1'b1;
    fval[3]   = 1'b0;
    for (int n = 0; n < 4; n++) begin
      pulse_in[3] = 1'b1;
      exp_q.push_back(3);
      step();
    end
    pulse_in = '0;
    chk("s4_pend3", pend_of(3), 3);
    chk("s4_req_high", int'(req_out[3]), 1);
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("s4_req_cleared", int'(req_out), 0);
    chk("s4_pend_cleared", int'(pend_cnt), 0);
    chk("s4_busy_cleared", int'(busy), 0);
    chk("s4_ovf_cleared", int'(ovf), 0);
    chk("s4_done_cleared", int'(done), 0);
    rst = 1'b0;

    // Stale ack on channel 2 across reset release
    repeat (4) step();
    base = done_seen[2];
    pulse_in[2] = 1'b1;
    exp_q.push_back(2);
    step();
    pulse_in = '0;
    chk("s5_req_held", int'(req_out[2]), 0);
    chk("s5_pend1", pend_of(2), 1);
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      if ((req_out[2] !== 1'b0) || (pend_of(2) != 1)) bad++;
    end
    chk("s5_hold_while_ack", bad, 0);
    fval[2] = 1'b0;
    step();
    chk("s5_req_low_e1", int'(req_out[2]), 0);
    step();
    chk("s5_req_low_e2", int'(req_out[2]), 0);
    step();
    chk("s5_req_low_e3", int'(req_out[2]), 0);
    step();
    chk("s5_req_rises", int'(req_out[2]), 1);
    chk("s5_pend0", pend_of(2), 0);
    forced[2] = 1'b0;
    dly[2]    = 2;
    drain(200, "s5");
    chk("s5_done_count", done_seen[2] - base, 1);

    // Concurrency: simultaneous pulses then randomized bursts, random ack delays
    forced = '0;
    for (int r = 0; r < 5; r++) begin
      repeat (12) step();
      for (int i = 0; i < NCH; i++) begin
        dly[i]  = $urandom_range(0, 10);
        b6[i]   = done_seen[i];
        cnt[i]  = (r == 0) ? 1 : $urandom_range(0, PMAX + 1);
        left[i] = cnt[i];
      end
      repeat (12) step();
      if (r == 0) begin
        pulse_in = '1;
        for (int i = 0; i < NCH; i++) exp_q.push_back(i);
        step();
        pulse_in = '0;
      end else begin
        for (int t = 0; t < 24; t++) begin
          for (int i = 0; i < NCH; i++) begin
            if ((left[i] > 0) && (($urandom_range(0, 2) == 0) || (left[i] >= 24 - t))) begin
              pulse_in[i] = 1'b1;
              exp_q.push_back(i);
              left[i]--;
            end else begin
              pulse_in[i] = 1'b0;
            end
          end
          step();
        end
        pulse_in = '0;
      end
      drain(1500, $sformatf("s6_r%0d", r));
      for (int i = 0; i < NCH; i++)
        chk($sformatf("s6_r%0d_done_ch%0d", r, i), done_seen[i] - b6[i], cnt[i]);
      chk($sformatf("s6_r%0d_ovf", r), int'(ovf), 0);
      chk($sformatf("s6_r%0d_pend", r), int'(pend_cnt), 0);
    end

    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdshk_pulse_tx.md
HDSHK_PULSE_TX -- requirements
Module: hdshk_pulse_tx

Interface
Parameters:
REQ-001 The block SHALL have parameter NCH, default 4, the number of independent channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the ack synchronizer depth (legal values 2..4).
REQ-003 The block SHALL have parameter CNT_W, default 3, the pending-counter width per channel; max pending PMAX = 2^CNT_W-1.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port pulse_in, input, NCH bits: event request; each cycle bit i is high counts as one event for channel i.
REQ-007 The block SHALL have port ack_async, input, NCH bits: acknowledge from the remote domain, asynchronous to clk.
REQ-008 The block SHALL have port req_out, output, NCH bits: four-phase request level to the remote domain, registered.
REQ-009 The block SHALL have port busy, output, NCH bits: channel i state != IDLE or pend[i] != 0.
REQ-010 The block SHALL have port done, output, NCH bits: one-cycle pulse on handshake completion, registered.
REQ-011 The block SHALL have port pend_cnt, output, NCH*CNT_W bits: pending-event count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 The block SHALL have port ovf, output, NCH bits: sticky overflow flag per channel.
REQ-013 The block SHALL have port ovf_clr, input, NCH bits: clears ovf[i] when high.

Function
REQ-014 Each ack_async[i] SHALL pass through SYNC_STAGES flops; the last stage is ack_s[i]; no other logic samples ack_async.
REQ-015 Each channel SHALL run a 3-state FSM: IDLE (req_out=0), REQ (req_out=1), WAIT_LOW (req_out=0); req_out SHALL be a registered state decode.
REQ-016 IDLE -> REQ SHALL occur when ack_s=0 and (pulse_in=1 or pend>0).
REQ-017 On the IDLE -> REQ transition, if pulse_in=1 that event SHALL be consumed with pend unchanged; otherwise pend SHALL decrement by 1.
REQ-018 In IDLE with ack_s=1, the FSM SHALL hold and events SHALL accumulate in pend.
REQ-019 REQ -> WAIT_LOW SHALL occur when ack_s=1; the FSM SHALL hold in REQ otherwise, with no timeout.
REQ-020 WAIT_LOW -> IDLE SHALL occur when ack_s=0, with done[i]=1 in the following cycle only.
REQ-021 In REQ or WAIT_LOW, pulse_in=1 SHALL increment pend.
REQ-022 With pend=PMAX, an incoming event SHALL be dropped, pend SHALL remain PMAX, and ovf SHALL be set the next cycle.
REQ-023 pend SHALL never wrap: no decrement below 0, no increment above PMAX.
REQ-024 An event in IDLE with pend=PMAX and ack_s=0 SHALL be consumed directly and SHALL NOT cause overflow.
REQ-025 ovf_clr and a new overflow in the same cycle SHALL leave ovf=1 (set wins).
REQ-026 Latency: pulse_in high at edge n in IDLE with ack_s=0 SHALL give req_out=1 after edge n.
REQ-027 Latency: ack_async rising before edge k SHALL give req_out=0 after edge k+SYNC_STAGES.
REQ-028 Channels SHALL be fully independent with no arbitration; simultaneous events on all channels SHALL be legal.

Reset
REQ-029 rst=1 at an edge SHALL force all FSMs to IDLE and clear req_out, done, busy, pend, ovf and all synchronizer flops to 0.
REQ-030 rst SHALL override all other inputs, including mid-handshake; pending events SHALL be discarded.
REQ-031 After rst deasserts, a channel whose ack_async is still high SHALL hold in IDLE until ack_s=0.

Verification
REQ-032 The bench SHALL cover single event: NCH=4, SYNC_STAGES=2, pulse_in[0] for 1 cycle, remote model echoes req as ack after 3 cycles -> req_out[0] 1 cycle later, one done[0] pulse, pend_cnt stays 0, busy[0] low after done.
REQ-033 The bench SHALL cover queuing: 5 consecutive pulse_in[1] cycles with ack held low -> first consumed, pend=4; after release, 5 full handshakes and 5 done pulses, pend reaches 0.
REQ-034 The bench SHALL cover overflow: CNT_W=3, ack stuck low, 9 event cycles -> 1 consumed, pend=7, ovf=1, 1 event dropped; ovf_clr -> ovf=0, pend=7.
REQ-035 The bench SHALL cover reset mid-operation: rst during REQ with pend=3 -> next cycle req_out=0, pend=0, busy=0, ovf=0.
REQ-036 The bench SHALL cover stale ack: ack_async[2] high across reset release, then pulse -> req_out[2] stays 0 until 2 cycles after ack falls; pend=1 meanwhile.
REQ-037 The bench SHALL cover concurrency: all 4 channels pulsed in the same cycle with random ack delays 0..10 cycles -> exactly 4 done pulses, ovf=0, and req_out never rises while ack_s is high.
